// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_pkg
//  Brief    : Operation encodings and FSM states for the multiply/divide unit
//  Revision : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mdu_step.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_step
//  Brief    : One shift-add (multiply) or restoring shift-subtract (divide) step
//  Revision : 1.0 - initial release
// ============================================================================
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic                 i_mode,     // 0 multiply, 1 divide
    input  logic [2*WIDTH-1:0]   i_acc,
    input  logic [WIDTH-1:0]     i_operand,
    input  logic                 i_bit,
    output logic [2*WIDTH-1:0]   o_acc,
    output logic                 o_qBit
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_remShift;
    logic [WIDTH:0] w_diff;

    always_comb begin
        w_sum      = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + {1'b0, (i_bit ? i_operand : {WIDTH{1'b0}})};
        w_remShift = {i_acc[2*WIDTH-1:WIDTH], i_bit};
        w_diff     = w_remShift - {1'b0, i_operand};
        o_acc      = '0;
        o_qBit     = 1'b0;
        if (!i_mode) begin
            o_acc = {w_sum, i_acc[WIDTH-1:1]};
        end else if (!w_diff[WIDTH]) begin
            // Quotient bit slot is left clear; the caller merges o_qBit in.
            o_acc  = {w_diff[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
            o_qBit = 1'b1;
        end else begin
            o_acc  = {w_remShift[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
        end
    end

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mult_div_unit
//  Brief    : Multicycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO
//  Revision : 1.0 - initial release
// ============================================================================
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             write_hi,
    input  logic             write_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int               CNT_W  = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_isDiv;
    logic                 r_signA;
    logic                 r_signB;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_opnd;

    logic                 w_signA;
    logic                 w_signB;
    logic [WIDTH-1:0]     w_magA;
    logic [WIDTH-1:0]     w_magB;
    logic                 w_curBit;
    logic [2*WIDTH-1:0]   w_nextAcc;
    logic                 w_qBit;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quot;
    logic [WIDTH-1:0]     w_rem;

    always_comb begin
        w_signA  = ~op[0] & a[WIDTH-1];
        w_signB  = ~op[0] & b[WIDTH-1];
        w_magA   = w_signA ? -a : a;
        w_magB   = w_signB ? -b : b;
        // Multiply consumes the multiplier LSB; divide consumes the dividend MSB.
        w_curBit = r_isDiv ? r_acc[WIDTH-1] : r_acc[0];
        w_prod   = (r_signA ^ r_signB) ? -r_acc : r_acc;
        w_quot   = (r_signA ^ r_signB) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        w_rem    = r_signA ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    end

    mdu_step #(
        .WIDTH     (WIDTH)
    ) u_step (
        .i_mode    (r_isDiv),
        .i_acc     (r_acc),
        .i_operand (r_opnd),
        .i_bit     (w_curBit),
        .o_acc     (w_nextAcc),
        .o_qBit    (w_qBit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_isDiv  <= 1'b0;
            r_signA  <= 1'b0;
            r_signB  <= 1'b0;
            r_acc    <= '0;
            r_opnd   <= '0;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (op[1] && (b == '0)) begin
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                        end else begin
                            r_isDiv <= op[1];
                            r_signA <= w_signA;
                            r_signB <= w_signB;
                            r_acc   <= op[1] ? {{WIDTH{1'b0}}, w_magA} : {{WIDTH{1'b0}}, w_magB};
                            r_opnd  <= op[1] ? w_magB : w_magA;
                            r_cnt   <= '0;
                            busy    <= 1'b1;
                            r_state <= RUN;
                        end
                    end else begin
                        if (write_hi) hi <= wdata;
                        if (write_lo) lo <= wdata;
                    end
                end
                RUN: begin
                    r_acc <= w_nextAcc | {{(2*WIDTH-1){1'b0}}, w_qBit};
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == c_LAST) r_state <= FIX;
                end
                FIX: begin
                    if (r_isDiv) begin
                        hi <= w_rem;
                        lo <= w_quot;
                    end else begin
                        hi <= w_prod[2*WIDTH-1:WIDTH];
                        lo <= w_prod[WIDTH-1:0];
                    end
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_div_unit
//  Brief    : Directed vector bench for mult_div_unit (WIDTH=32)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        write_hi;
    logic        write_lo;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    int nChecks = 0;
    int nErrors = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
    } vec_t;

    vec_t vecs [10];

    mult_div_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .write_hi (write_hi),
        .write_lo (write_lo),
        .wdata    (wdata),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one operation and wait for done; lat = edges from accept to done.
    task automatic runOp(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output logic busyOk);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        a      = 32'hDEAD_BEEF;
        b      = 32'h0;
        lat    = -1;
        busyOk = busy;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = n;
                busyOk = busyOk & ~busy;
                break;
            end
            busyOk = busyOk & busy;
        end
    endtask

    initial begin
        int   lat;
        logic busyOk;
        logic sawDone;

        vecs[0] = '{2'b00, 32'hFFFF_FFFF, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFF9};
        vecs[1] = '{2'b01, 32'hFFFF_FFFF, 32'd7,         32'h0000_0006, 32'hFFFF_FFF9};
        vecs[2] = '{2'b11, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E};
        vecs[3] = '{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[5] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[6] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[7] = '{2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
        vecs[8] = '{2'b11, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 32'hFFFF_FFFF};
        vecs[9] = '{2'b00, 32'd3,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFF1};

        reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        write_hi = 1'b0; write_lo = 1'b0; wdata = '0;
        repeat (2) @(negedge clk);
        check("reset_state", {hi, lo}, 64'h0);
        check("reset_flags", {61'h0, busy, done, div_zero}, 64'h0);
        reset = 1'b0;

        // Consecutive vectors also exercise start in the done cycle.
        for (int i = 0; i < 10; i++) begin
            runOp(vecs[i].op, vecs[i].a, vecs[i].b, lat, busyOk);
            check($sformatf("vec%0d_hilo", i), {hi, lo}, {vecs[i].expHi, vecs[i].expLo});
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd33);
            check($sformatf("vec%0d_busy", i), {63'h0, busyOk}, 64'h1);
            check($sformatf("vec%0d_divzero", i), {63'h0, div_zero}, 64'h0);
        end

        // MTHI / MTLO, then zero-divisor divide with a competing write_lo.
        @(negedge clk); write_hi = 1'b1; wdata = 32'h1234;
        @(negedge clk); write_hi = 1'b0; write_lo = 1'b1; wdata = 32'h5678;
        @(negedge clk); write_lo = 1'b0;
        check("mthi_mtlo", {hi, lo}, {32'h1234, 32'h5678});
        op = 2'b10; a = 32'd5; b = 32'd0; start = 1'b1; write_lo = 1'b1; wdata = 32'h9999;
        @(posedge clk); #1;
        start = 1'b0; write_lo = 1'b0;
        check("dz_flags", {61'h0, busy, done, div_zero}, 64'h3);
        check("dz_hilo", {hi, lo}, {32'h1234, 32'h5678});
        @(posedge clk); #1;
        check("dz_pulse_end", {61'h0, busy, done, div_zero}, 64'h0);

        // Mid-operation start/write are ignored; async reset discards the op.
        @(negedge clk);
        op = 2'b00; a = 32'hFFFF_FFFF; b = 32'd7; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        op = 2'b01; start = 1'b1; write_lo = 1'b1; wdata = 32'hAAAA;
        @(posedge clk); #1;
        start = 1'b0; write_lo = 1'b0;
        check("midop_ignored", {62'h0, busy, done}, 64'h2);
        check("midop_lo", {32'h0, lo}, {32'h0, 32'h5678});
        repeat (10) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("async_reset", {hi, lo, 29'h0, busy, done, div_zero}, 96'h0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        sawDone = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            sawDone = sawDone | done | busy;
        end
        check("no_done_after_reset", {63'h0, sawDone}, 64'h0);

        runOp(2'b01, 32'd3, 32'd5, lat, busyOk);
        check("post_reset_multu", {hi, lo}, {32'h0, 32'd15});
        check("post_reset_latency", 64'(lat), 64'd33);

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule
`default_nettype wire
